// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - scan-set-2 codes, ASCII constants and receive-state enum for ps2_keyboard
package ps2_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;

  localparam logic [7:0] ASC_ESC = 8'h1B;
  localparam logic [7:0] ASC_CR  = 8'h0D;
  localparam logic [7:0] ASC_BS  = 8'h08;
  localparam logic [7:0] ASC_TAB = 8'h09;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} rx_state_t;

  function automatic logic is_letter(input logic [7:0] c);
    return (c >= 8'h61) && (c <= 8'h7A);
  endfunction

  // VT52 final byte for an extended arrow code, 0 when not an arrow
  function automatic logic [7:0] arrow_letter(input logic [7:0] c);
    case (c)
      SC_UP:    return 8'h41;
      SC_DOWN:  return 8'h42;
      SC_RIGHT: return 8'h43;
      SC_LEFT:  return 8'h44;
      default:  return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ps2_scancode_rom.sv
// rtl/ps2_scancode_rom.sv - scan-set-2 to {unshifted, shifted} ASCII, US layout; 0 = unmapped
module ps2_scancode_rom
  import ps2_pkg::*;
(
  input  logic [7:0] i_code,
  output logic [7:0] o_unshifted,
  output logic [7:0] o_shifted
);

  logic [15:0] w_pair;

  always_comb begin
    w_pair = 16'h0000;
    case (i_code)
      8'h1C: w_pair = {"a", "A"};
      8'h32: w_pair = {"b", "B"};
      8'h21: w_pair = {"c", "C"};
      8'h23: w_pair = {"d", "D"};
      8'h24: w_pair = {"e", "E"};
      8'h2B: w_pair = {"f", "F"};
      8'h34: w_pair = {"g", "G"};
      8'h33: w_pair = {"h", "H"};
      8'h43: w_pair = {"i", "I"};
      8'h3B: w_pair = {"j", "J"};
      8'h42: w_pair = {"k", "K"};
      8'h4B: w_pair = {"l", "L"};
      8'h3A: w_pair = {"m", "M"};
      8'h31: w_pair = {"n", "N"};
      8'h44: w_pair = {"o", "O"};
      8'h4D: w_pair = {"p", "P"};
      8'h15: w_pair = {"q", "Q"};
      8'h2D: w_pair = {"r", "R"};
      8'h1B: w_pair = {"s", "S"};
      8'h2C: w_pair = {"t", "T"};
      8'h3C: w_pair = {"u", "U"};
      8'h2A: w_pair = {"v", "V"};
      8'h1D: w_pair = {"w", "W"};
      8'h22: w_pair = {"x", "X"};
      8'h35: w_pair = {"y", "Y"};
      8'h1A: w_pair = {"z", "Z"};
      8'h16: w_pair = {"1", "!"};
      8'h1E: w_pair = {"2", "@"};
      8'h26: w_pair = {"3", "#"};
      8'h25: w_pair = {"4", "$"};
      8'h2E: w_pair = {"5", "%"};
      8'h36: w_pair = {"6", "^"};
      8'h3D: w_pair = {"7", "&"};
      8'h3E: w_pair = {"8", "*"};
      8'h46: w_pair = {"9", "("};
      8'h45: w_pair = {"0", ")"};
      8'h0E: w_pair = {8'h60, "~"};
      8'h4E: w_pair = {"-", "_"};
      8'h55: w_pair = {"=", "+"};
      8'h54: w_pair = {"[", "{"};
      8'h5B: w_pair = {"]", "}"};
      8'h5D: w_pair = {8'h5C, 8'h7C};
      8'h4C: w_pair = {";", ":"};
      8'h52: w_pair = {8'h27, 8'h22};
      8'h41: w_pair = {",", "<"};
      8'h49: w_pair = {".", ">"};
      8'h4A: w_pair = {"/", "?"};
      8'h29: w_pair = {" ", " "};
      8'h5A: w_pair = {ASC_CR, ASC_CR};
      8'h66: w_pair = {ASC_BS, ASC_BS};
      8'h76: w_pair = {ASC_ESC, ASC_ESC};
      8'h0D: w_pair = {ASC_TAB, ASC_TAB};
      default: w_pair = 16'h0000;
    endcase
  end

  assign o_unshifted = w_pair[15:8];
  assign o_shifted   = w_pair[7:0];

endmodule

// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - PS/2 keyboard receiver, modifier tracking and ASCII stream source
// PS2_ARROW_VT52_EN: extended arrows emit the two-byte VT52 sequence ESC, A/B/C/D
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40000
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       frame_error,
  output logic       overrun
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic r_clk_s1, r_clk_s2, r_clk_prev, r_dat_s1, r_dat_s2;
  rx_state_t r_state;
  logic [7:0] r_sr;
  logic [2:0] r_bit_cnt;
  logic [CW-1:0] r_idle_cnt;
  logic r_par_ok, r_sc_valid, r_frame_error;
  logic r_brk, r_ext, r_lshift, r_rshift, r_ctrl, r_caps;
  logic [7:0] r_tdata;
  logic r_tvalid, r_overrun;
  logic w_fall, w_timeout, w_prefix, w_shift, w_new_valid, w_busy;
  logic [7:0] w_lo, w_hi, w_ascii, w_new_data;
`ifdef PS2_ARROW_VT52_EN
  logic r_pend;
  logic [7:0] r_pend_char, w_arrow_char;
  logic w_arrow;
`endif

  // Lines idle high, so the synchronizers reset to 1 to avoid a spurious edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {r_clk_s1, r_clk_s2, r_clk_prev, r_dat_s1, r_dat_s2} <= 5'b11111;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall    = r_clk_prev & ~r_clk_s2;
  assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_idle_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_sr          <= '0;
      r_bit_cnt     <= '0;
      r_idle_cnt    <= '0;
      r_par_ok      <= 1'b0;
      r_sc_valid    <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_sc_valid    <= 1'b0;
      r_frame_error <= 1'b0;
      r_idle_cnt    <= (w_fall || r_state == ST_IDLE) ? '0 : r_idle_cnt + 1'b1;
      if (w_timeout) begin
        r_state       <= ST_IDLE;
        r_frame_error <= 1'b1;
      end else if (w_fall) begin
        case (r_state)
          ST_IDLE: begin
            if (!r_dat_s2) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end else begin
              r_frame_error <= 1'b1;
            end
          end
          ST_DATA: begin
            r_sr      <= {r_dat_s2, r_sr[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
          end
          ST_PARITY: begin
            r_par_ok <= ^{r_sr, r_dat_s2};
            r_state  <= ST_STOP;
          end
          ST_STOP: begin
            if (r_dat_s2 && r_par_ok) r_sc_valid <= 1'b1;
            else r_frame_error <= 1'b1;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  ps2_scancode_rom u_rom (
    .i_code      (r_sr),
    .o_unshifted (w_lo),
    .o_shifted   (w_hi)
  );

  assign w_prefix = (r_sr == SC_BREAK) || (r_sr == SC_EXT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {r_brk, r_ext, r_lshift, r_rshift, r_ctrl, r_caps} <= 6'b0;
    end else if (r_sc_valid) begin
      if (r_sr == SC_BREAK) begin
        r_brk <= 1'b1;
      end else if (r_sr == SC_EXT) begin
        r_ext <= 1'b1;
      end else begin
        r_brk <= 1'b0;
        r_ext <= 1'b0;
        case (r_sr)
          SC_LSHIFT: if (!r_ext) r_lshift <= ~r_brk;
          SC_RSHIFT: if (!r_ext) r_rshift <= ~r_brk;
          SC_CTRL:   r_ctrl <= ~r_brk;
          SC_CAPS:   if (!r_ext && !r_brk) r_caps <= ~r_caps;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    w_shift = r_lshift | r_rshift;
    if (is_letter(w_lo)) w_ascii = (w_shift ^ r_caps) ? w_hi : w_lo;
    else w_ascii = w_shift ? w_hi : w_lo;
    if (r_ctrl && w_ascii[7:6] == 2'b01) w_ascii = w_ascii & 8'h1F;
    w_new_valid = r_sc_valid && !w_prefix && !r_brk && !r_ext && (w_lo != 8'h00);
    w_new_data  = w_ascii;
`ifdef PS2_ARROW_VT52_EN
    w_arrow_char = arrow_letter(r_sr);
    w_arrow = r_sc_valid && r_ext && !r_brk && (w_arrow_char != 8'h00);
    if (w_arrow) begin
      w_new_valid = 1'b1;
      w_new_data  = ASC_ESC;
    end
    w_busy = r_pend | (r_tvalid & ~m_axis_tready);
`else
    w_busy = r_tvalid & ~m_axis_tready;
`endif
  end

  // A handshake frees the slot in the same cycle, so a simultaneous arrival is loaded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tvalid  <= 1'b0;
      r_tdata   <= 8'h00;
      r_overrun <= 1'b0;
`ifdef PS2_ARROW_VT52_EN
      r_pend      <= 1'b0;
      r_pend_char <= 8'h00;
`endif
    end else begin
      r_overrun <= 1'b0;
      if (r_tvalid && m_axis_tready) r_tvalid <= 1'b0;
`ifdef PS2_ARROW_VT52_EN
      if (r_pend && !r_tvalid) begin
        r_tvalid <= 1'b1;
        r_tdata  <= r_pend_char;
        r_pend   <= 1'b0;
      end
`endif
      if (w_new_valid) begin
        if (w_busy) begin
          r_overrun <= 1'b1;
        end else begin
          r_tvalid <= 1'b1;
          r_tdata  <= w_new_data;
`ifdef PS2_ARROW_VT52_EN
          if (w_arrow) begin
            r_pend      <= 1'b1;
            r_pend_char <= w_arrow_char;
          end
`endif
        end
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign frame_error   = r_frame_error;
  assign overrun       = r_overrun;

endmodule
